// File: rtl/collision_pkg.sv
// Shared event codes and widths for the collision event arbiter.
// The enum defines the event codes in order; bottom has the highest priority.
package collision_pkg;

   localparam int NUM_EVENTS = 7;
   localparam int COOL_W     = 4;
   localparam int CODE_W     = 3;

   typedef enum logic [CODE_W-1:0] {
      BOTTOM    = 3'd0,
      OBST_BAD  = 3'd1,
      OBST_GOOD = 3'd2,
      FLIPPER   = 3'd3,
      TOP       = 3'd4,
      LEFT      = 3'd5,
      RIGHT     = 3'd6
   } coll_event_e;

endpackage

// File: rtl/coll_priority_enc.sv
// Lowest-set-bit encoder over the event vector.
// Bit 0 (bottom) wins, so it is the highest-priority event.
import collision_pkg::*;

module coll_priority_enc (
   input  logic [NUM_EVENTS-1:0] vec,
   output logic [CODE_W-1:0]     code,
   output logic                  any
);

   always_comb begin
      code = '0;
      any  = |vec;
      // Scan downwards so the last hit is the lowest set bit.
      for (int i = NUM_EVENTS - 1; i >= 0; i--) begin
         if (vec[i]) begin
            code = CODE_W'(i);
         end
      end
   end

endmodule

// File: rtl/collision_event_arbiter.sv
// Accumulates collision pulses per frame, snapshots them at the frame boundary and
// dispatches one event at a time over valid/ready, with a per-event frame cooldown.
import collision_pkg::COOL_W;
import collision_pkg::CODE_W;

module collision_event_arbiter #(
   parameter int COOLDOWN_FRAMES = 4,
   parameter int NUM_EVENTS      = collision_pkg::NUM_EVENTS
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start_of_frame,
   input  logic [NUM_EVENTS-1:0] coll_in,
   output logic                  event_valid,
   output logic [CODE_W-1:0]     event_code,
   input  logic                  event_ready,
   output logic                  busy,
   output logic                  overrun
);

   localparam logic [0:0] IDLE    = 1'b0;
   localparam logic [0:0] PRESENT = 1'b1;

   logic [0:0]            state_reg;
   logic [CODE_W-1:0]     event_code_reg;
   logic [NUM_EVENTS-1:0] acc_reg;
   logic [NUM_EVENTS-1:0] pend_reg;
   logic                  overrun_reg;

   logic                  handshake;
   logic [NUM_EVENTS-1:0] mask;
   logic [NUM_EVENTS-1:0] accept_vec;
   logic [NUM_EVENTS-1:0] snap;
   logic [NUM_EVENTS-1:0] rem;
   logic [NUM_EVENTS-1:0] pend_next;
   logic [CODE_W-1:0]     enc_code;
   logic                  enc_any;

   assign handshake  = (state_reg == PRESENT) && event_ready;
   assign accept_vec = handshake ? (NUM_EVENTS'(1) << event_code_reg) : '0;
   // The accepted code is about to enter cooldown, so it is masked from a coincident snapshot.
   assign snap       = start_of_frame ? (acc_reg & ~mask & ~accept_vec) : '0;
   assign rem        = pend_reg & ~accept_vec;
   assign pend_next  = (pend_reg | snap) & ~accept_vec;

   coll_priority_enc u_enc (
      .vec  (rem),
      .code (enc_code),
      .any  (enc_any)
   );

   genvar gi;
   generate
      for (gi = 0; gi < NUM_EVENTS; gi++) begin : g_cool
         logic [COOL_W-1:0] cool_reg;

         assign mask[gi] = (cool_reg != '0);

         always_ff @(posedge clk) begin
            if (reset) begin
               cool_reg <= '0;
            end else if (accept_vec[gi]) begin
               cool_reg <= COOL_W'(COOLDOWN_FRAMES);
            end else if (start_of_frame && (cool_reg != '0)) begin
               cool_reg <= cool_reg - 1'b1;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         event_code_reg <= '0;
         acc_reg        <= '0;
         pend_reg       <= '0;
         overrun_reg    <= 1'b0;
      end else begin
         // A pulse coincident with the boundary starts the new frame's accumulation.
         acc_reg     <= start_of_frame ? coll_in : (acc_reg | coll_in);
         pend_reg    <= pend_next;
         overrun_reg <= start_of_frame && (pend_reg != '0) && (snap != '0);

         // Selection always works from the registered pend, so a snapshot is seen a cycle later.
         if (state_reg == IDLE) begin
            if (enc_any) begin
               state_reg      <= PRESENT;
               event_code_reg <= enc_code;
            end
         end else if (event_ready) begin
            if (enc_any) begin
               event_code_reg <= enc_code;
            end else begin
               state_reg <= IDLE;
            end
         end
      end
   end

   assign event_valid = (state_reg == PRESENT);
   assign event_code  = event_code_reg;
   assign busy        = (pend_reg != '0);
   assign overrun     = overrun_reg;

endmodule

// File: doc/collision_event_arbiter.md
# collision_event_arbiter

Converts the per-pixel collision pulses produced by the collision detector into an ordered stream of discrete collision events, at most one per event code per frame. It accumulates sticky flags during the active frame and snapshots them at `start_of_frame`. It then dispatches them one at a time, in fixed priority, over a valid/ready handshake to the ball-physics and scoring logic. A per-event cooldown suppresses re-reporting a collision that persists across consecutive frames.

## Interface
- `COOLDOWN_FRAMES`, default 4: frames an event code stays masked after it is dispatched; legal range 1..15.
- `NUM_EVENTS`, default 7: number of event codes; fixed by the package, not meant to be overridden.

Ports:
- `clk`  in  1: single system clock.
- `reset`  in  1: synchronous, active-high reset.
- `start_of_frame`  in  1: one-cycle pulse marking the frame boundary.
- `coll_in`  in  7: raw collision pulses, in bit order bottom, obstacle_bad, obstacle_good, flipper, top, left, right (bit 0 = bottom).
- `event_valid`  out  1: an event is presented.
- `event_code`  out  3: code of the presented event; see package.
- `event_ready`  in  1: consumer accepts the event.
- `busy`  out  1: pending snapshot is nonzero.
- `overrun`  out  1: one-cycle pulse, a new snapshot merged into undispatched events.

## Operation
- Sticky register `acc[6:0]`:
  - Each cycle, `acc |= coll_in`.
  - On `start_of_frame`, `acc` is cleared and loaded with that cycle's `coll_in`, so pulses coincident with the boundary belong to the new frame.
- Snapshot on `start_of_frame`: `pend <= pend | (acc & ~mask)`, where `mask[i] = (cool[i] != 0)`.
  - `mask` is evaluated using the cooldown values before this cycle's decrement.
  - If `pend` is nonzero at that moment and the new contribution is nonzero, `overrun` pulses.
- Cooldown counters `cool[i]` are 4 bits each:
  - Decrement on `start_of_frame` when nonzero.
  - Load `COOLDOWN_FRAMES` when event `i` completes a handshake.
  - Load takes precedence over decrement in the same cycle.
- States:
  - IDLE: `pend == 0`, `event_valid = 0`. Go to PRESENT in the cycle after `pend` becomes nonzero.
  - PRESENT: `event_valid = 1`, `event_code` = lowest set bit of `pend`, so bottom has highest priority.
    - On `event_valid && event_ready`: clear that bit and load its cooldown.
    - Next cycle: present the next set bit, or go to IDLE if none remain.
- `event_code` and `event_valid` are registered. While `event_valid && !event_ready`, `event_code` is held stable even if a snapshot adds a higher-priority bit. Re-selection occurs only after the handshake.
- Snapshot and handshake in the same cycle: the accepted bit is cleared and the new bits are OR-ed in, both in that cycle. An accepted code that is also freshly snapshotted is dropped, because it was masked by cooldown.
- `busy = (pend != 0)`.

## Timing
- Reset values: `acc = 0`, `pend = 0`, all `cool = 0`, `event_valid = 0`, `event_code = 0`, `overrun = 0`, `busy = 0`, state IDLE. Reset mid-dispatch discards all pending events.
- Latency: `start_of_frame` at cycle T gives `pend` updated at T+1 and the first `event_valid` at T+2.
- Throughput: one event per cycle while `event_ready` is held high.
- `coll_in` is sampled every cycle; a pulse of any width registers once per frame.

## Structure
- Package `collision_pkg`:
  - Enum `coll_event_e`: BOTTOM=0, OBST_BAD=1, OBST_GOOD=2, FLIPPER=3, TOP=4, LEFT=5, RIGHT=6.
  - `NUM_EVENTS = 7`.
  - `COOL_W = 4`.
- Sub-module `coll_priority_enc`: a 7-bit lowest-set-bit encoder that outputs the code and an any-set flag.
- Cooldown counters are a generate loop inside the top module.

## Test plan
- **Single event:**
  - Stimulus: `coll_in[3]` pulses at cycle 100, `start_of_frame` at 200, `event_ready = 1`.
  - Response: `event_valid` for exactly one cycle at 202 with `event_code = 3`, then IDLE.
- **Priority ordering:**
  - Stimulus: bits 6, 2 and 0 set during one frame, `event_ready = 1`.
  - Response: codes 0, 2, 6 on three consecutive cycles.
- **Backpressure:**
  - Stimulus: `event_ready = 0` for 5 cycles, with a snapshot adding bit 0 while code 2 is presented.
  - Response: code 2 held stable, then code 0 after the handshake.
- **Cooldown:**
  - Stimulus: `COOLDOWN_FRAMES = 4`, bit 1 asserted in 6 consecutive frames.
  - Response: reported in frame 1 and frame 6 only.
- **Boundary pulse:**
  - Stimulus: `coll_in[4]` coincident with `start_of_frame`.
  - Response: not in this snapshot, reported at the next frame's snapshot.
- **Overrun and reset:**
  - Stimulus: `event_ready = 0` across two frames with new bits, then `reset` for 1 cycle.
  - Response: `overrun` pulses once, then all outputs return to 0 the cycle after reset.
